// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared size/state types and RAM lane helpers for mem_access_unit
package mem_access_pkg;
  typedef enum logic [1:0] {SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10, SZ_BAD = 2'b11} size_e;
  typedef enum logic [2:0] {IDLE, WRITE, RD_ISSUE, RD_WAIT, RESP} state_e;
  function automatic logic [3:0] byteena_for(size_e size, logic [1:0] lane);
    return size == SZ_BYTE ? 4'b0001 << lane :
           size == SZ_HALF ? (lane[1] ? 4'b1100 : 4'b0011) :
           size == SZ_WORD ? 4'b1111 : 4'b0000;
  endfunction
  function automatic logic [31:0] replicate_store(size_e size, logic [31:0] wdata);
    return size == SZ_BYTE ? {4{wdata[7:0]}} :
           size == SZ_HALF ? {2{wdata[15:0]}} : wdata;
  endfunction
  // Halfwords use only addr[1]; bytes use the full lane, little-endian.
  function automatic logic [31:0] extract_load(size_e size, logic [1:0] lane, logic sgn, logic [31:0] q);
    logic [31:0] sh;
    sh = q >> (size == SZ_HALF ? {lane[1], 4'b0000} : {lane, 3'b000});
    return size == SZ_BYTE ? {{24{sgn & sh[7]}}, sh[7:0]} :
           size == SZ_HALF ? {{16{sgn & sh[15]}}, sh[15:0]} : q;
  endfunction
  function automatic logic misaligned(size_e size, logic [1:0] lo);
    return size == SZ_BAD || (size == SZ_HALF && lo[0]) || (size == SZ_WORD && lo != 2'b00);
  endfunction
endpackage

// File: rtl/mem_access_unit_lane_align.sv
// mem_lane_align: store lane/byteena generation and load lane extraction
module mem_lane_align
  import mem_access_pkg::*;
(
  input  size_e       size,
  input  logic [1:0]  lane,
  input  logic        sgn,
  input  logic [31:0] wdata,
  input  logic [31:0] q,
  output logic [3:0]  byteena,
  output logic [31:0] data,
  output logic [31:0] rdata
);
  assign byteena = byteena_for(size, lane);
  assign data    = replicate_store(size, wdata);
  assign rdata   = extract_load(size, lane, sgn, q);
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: byte/half/word load-store initiator for the RAM32Bit dual-port word RAM
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int ADDR_W       = 16,
  parameter int READ_LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_error,
  output logic [3:0]        ram_byteena,
  output logic [31:0]       ram_data,
  output logic [ADDR_W-1:0] ram_rdaddress,
  output logic              ram_rden,
  output logic [ADDR_W-1:0] ram_wraddress,
  output logic              ram_wren,
  input  logic [31:0]       ram_q
);
  localparam int CW = READ_LATENCY > 1 ? $clog2(READ_LATENCY) : 1;
  state_e state, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0] lane_q;
  size_e size_q;
  logic sgn_q, err_q, bad;
  logic [31:0] wdata_q, rdata_q, st_data, ld_data;
  logic [3:0] st_be;
  logic [CW-1:0] cnt;
  assign bad = misaligned(size_e'(req_size), req_addr[1:0]) || (req_addr >> (ADDR_W + 2)) != 32'd0;
  mem_lane_align u_align (
    .size(size_q), .lane(lane_q), .sgn(sgn_q), .wdata(wdata_q), .q(ram_q),
    .byteena(st_be), .data(st_data), .rdata(ld_data)
  );
  always_comb begin
    state_d = state;
    case (state)
      IDLE:     if (req_valid) state_d = bad ? RESP : req_write ? WRITE : RD_ISSUE;
      WRITE:    state_d = IDLE;
      RD_ISSUE: state_d = RD_WAIT;
      RD_WAIT:  if (cnt == '0) state_d = RESP;
      RESP:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state   <= IDLE;
      addr_q  <= '0;
      lane_q  <= '0;
      size_q  <= SZ_BYTE;
      sgn_q   <= 1'b0;
      err_q   <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt     <= '0;
    end else begin
      state <= state_d;
      if (state == IDLE && req_valid) begin
        addr_q  <= req_addr[ADDR_W+1:2];
        lane_q  <= req_addr[1:0];
        size_q  <= size_e'(req_size);
        sgn_q   <= req_signed;
        wdata_q <= req_wdata;
        err_q   <= bad;
        rdata_q <= '0;
      end
      if (state == RD_ISSUE) cnt <= CW'(READ_LATENCY - 1);
      else if (state == RD_WAIT && cnt != '0) cnt <= cnt - CW'(1);
      if (state == RD_WAIT && cnt == '0) rdata_q <= ld_data;
    end
  assign req_ready     = state == IDLE;
  assign ram_wren      = state == WRITE;
  assign ram_rden      = state == RD_ISSUE;
  assign ram_wraddress = ram_wren ? addr_q : '0;
  assign ram_rdaddress = ram_rden ? addr_q : '0;
  assign ram_byteena   = ram_wren ? st_be : '0;
  assign ram_data      = ram_wren ? st_data : '0;
  assign resp_valid    = state == WRITE || state == RESP;
  assign resp_error    = state == RESP && err_q;
  assign resp_rdata    = resp_valid ? rdata_q : '0;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed checks of mem_access_unit against a 2-cycle RAM32Bit model
module tb_mem_access_unit;
  logic clk = 1'b0, rst = 1'b1;
  logic req_valid = 1'b0, req_write = 1'b0, req_signed = 1'b0;
  logic [1:0] req_size = 2'b00;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic req_ready, resp_valid, resp_error, ram_rden, ram_wren;
  logic [31:0] resp_rdata, ram_data, ram_q, r1;
  logic [3:0] ram_byteena;
  logic [15:0] ram_rdaddress, ram_wraddress;
  logic [31:0] mem [0:65535];
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_error(resp_error), .ram_byteena(ram_byteena),
    .ram_data(ram_data), .ram_rdaddress(ram_rdaddress), .ram_rden(ram_rden),
    .ram_wraddress(ram_wraddress), .ram_wren(ram_wren), .ram_q(ram_q)
  );

  // Registered address then registered output: q is valid at the second edge after rden.
  always @(posedge clk) begin
    if (ram_wren)
      for (int i = 0; i < 4; i++)
        if (ram_byteena[i]) mem[ram_wraddress][8*i +: 8] <= ram_data[8*i +: 8];
    if (ram_rden) r1 <= mem[ram_rdaddress];
    ram_q <= r1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic op(input string tag, input logic wr, input logic [1:0] sz, input logic sg,
                    input logic [31:0] addr, input logic [31:0] wd, input int exp_k,
                    input logic exp_err, input logic [31:0] exp_rd, input logic [15:0] exp_wa,
                    input logic [3:0] exp_be, input logic [31:0] exp_data, input logic hold);
    int k_resp = 0, n_resp = 0, n_wr = 0, n_rd = 0, n_both = 0, n_ready = 0;
    logic [31:0] c_rd = '0, c_data = '0;
    logic [15:0] c_wa = '0, c_ra = '0;
    logic [3:0] c_be = '0;
    logic c_err = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg; req_addr = addr; req_wdata = wd;
    @(posedge clk);
    #1;
    if (hold) begin
      req_write = 1'b1; req_size = 2'b10; req_addr = 32'h0000_0100;
    end else req_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k <= exp_k && req_ready) n_ready++;
      if (ram_wren && ram_rden) n_both++;
      if (ram_wren) begin
        n_wr++; c_wa = ram_wraddress; c_be = ram_byteena; c_data = ram_data;
      end
      if (ram_rden) begin
        n_rd++; c_ra = ram_rdaddress;
      end
      if (resp_valid) begin
        n_resp++;
        if (k_resp == 0) begin
          k_resp = k; c_rd = resp_rdata; c_err = resp_error;
        end
        req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    chk({tag, " resp_cycle"}, 32'(k_resp), 32'(exp_k));
    chk({tag, " resp_count"}, 32'(n_resp), 32'd1);
    chk({tag, " resp_error"}, 32'(c_err), 32'(exp_err));
    chk({tag, " resp_rdata"}, c_rd, exp_rd);
    chk({tag, " wren_count"}, 32'(n_wr), 32'(wr && !exp_err));
    chk({tag, " rden_count"}, 32'(n_rd), 32'(!wr && !exp_err));
    chk({tag, " strobe_overlap"}, 32'(n_both), 32'd0);
    chk({tag, " ready_while_busy"}, 32'(n_ready), 32'd0);
    if (wr && !exp_err) begin
      chk({tag, " wraddress"}, 32'(c_wa), 32'(exp_wa));
      chk({tag, " byteena"}, 32'(c_be), 32'(exp_be));
      chk({tag, " data"}, c_data, exp_data);
    end
    if (!wr && !exp_err) chk({tag, " rdaddress"}, 32'(c_ra), 32'(exp_wa));
  endtask

  initial begin
    int n_resp;
    #1;
    chk("reset ready", 32'(req_ready), 32'd1);
    chk("reset resp_valid", 32'(resp_valid), 32'd0);
    chk("reset strobes", {30'd0, ram_wren, ram_rden}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    //  tag     wr  sz     sg    addr          wdata         k  err   rdata         waddr     be       data
    op("SW",    1, 2'b10, 0, 32'h0002_BF20, 32'hABCD_FFFF, 1, 0, 32'h0,         16'd45000, 4'b1111, 32'hABCD_FFFF, 0);
    @(negedge clk);
    chk("idle byteena", 32'(ram_byteena), 32'd0);
    chk("idle data", ram_data, 32'd0);
    chk("idle wraddress", 32'(ram_wraddress), 32'd0);
    op("LW",    0, 2'b10, 0, 32'h0002_BF20, 32'h0,         4, 0, 32'hABCD_FFFF, 16'd45000, 4'b0000, 32'h0, 1);
    op("SB",    1, 2'b00, 0, 32'h0002_BF21, 32'h0000_0012, 1, 0, 32'h0,         16'd45000, 4'b0010, 32'h1212_1212, 0);
    op("LBU",   0, 2'b00, 0, 32'h0002_BF21, 32'h0,         4, 0, 32'h0000_0012, 16'd45000, 4'b0000, 32'h0, 0);
    op("LB",    0, 2'b00, 1, 32'h0002_BF23, 32'h0,         4, 0, 32'hFFFF_FFAB, 16'd45000, 4'b0000, 32'h0, 0);
    op("LH",    0, 2'b01, 1, 32'h0002_BF22, 32'h0,         4, 0, 32'hFFFF_ABCD, 16'd45000, 4'b0000, 32'h0, 0);
    op("LHU",   0, 2'b01, 0, 32'h0002_BF22, 32'h0,         4, 0, 32'h0000_ABCD, 16'd45000, 4'b0000, 32'h0, 0);
    op("LHU0",  0, 2'b01, 0, 32'h0002_BF20, 32'h0,         4, 0, 32'h0000_12FF, 16'd45000, 4'b0000, 32'h0, 0);
    op("SH2",   1, 2'b01, 0, 32'h0002_BF22, 32'h0000_5A5A, 1, 0, 32'h0,         16'd45000, 4'b1100, 32'h5A5A_5A5A, 0);
    op("LW2",   0, 2'b10, 0, 32'h0002_BF20, 32'h0,         4, 0, 32'h5A5A_12FF, 16'd45000, 4'b0000, 32'h0, 0);
    op("SH0",   1, 2'b01, 0, 32'h0002_BF22, 32'h0000_ABCD, 1, 0, 32'h0,         16'd45000, 4'b1100, 32'hABCD_ABCD, 0);
    op("LWmis", 0, 2'b10, 0, 32'h0002_BF22, 32'h0,         1, 1, 32'h0,         16'd0,     4'b0000, 32'h0, 0);
    op("SHmis", 1, 2'b01, 0, 32'h0002_BF21, 32'h0000_1234, 1, 1, 32'h0,         16'd0,     4'b0000, 32'h0, 0);
    op("LWoor", 0, 2'b10, 0, 32'h0004_0000, 32'h0,         1, 1, 32'h0,         16'd0,     4'b0000, 32'h0, 0);
    op("SZ11",  0, 2'b11, 0, 32'h0002_BF20, 32'h0,         1, 1, 32'h0,         16'd0,     4'b0000, 32'h0, 0);
    // Reset in the middle of a read: nothing may come back for it.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_signed = 1'b0; req_addr = 32'h0002_BF20;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("pre-reset rden", 32'(ram_rden), 32'd1);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("mid-reset rden", 32'(ram_rden), 32'd0);
    chk("mid-reset resp_valid", 32'(resp_valid), 32'd0);
    chk("mid-reset ready", 32'(req_ready), 32'd1);
    n_resp = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 2) rst = 1'b0;
      if (resp_valid) n_resp++;
    end
    chk("post-reset ready", 32'(req_ready), 32'd1);
    chk("post-reset resp_count", 32'(n_resp), 32'd0);
    op("LWrst", 0, 2'b10, 0, 32'h0002_BF20, 32'h0,         4, 0, 32'hABCD_12FF, 16'd45000, 4'b0000, 32'h0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
